spi_msg_seq: RTL

- Command sequencer between the byte-level SPI slave and the register file in the spi_msg design.
- Decodes the first byte of each message, then drives register read/write handshakes and supplies the MISO byte for every exchange.
- Runs entirely in the clk200MHz domain. SS and byte strobes arrive already synchronised to that clock.
- Message format:
  - 0x00 = status read.
  - 0x80|reg = read 4 bytes, MSB first.
  - 0xC0|reg = write 4 bytes, MSB first.

---
 rtl/spi_msg_pkg.sv | 26 ++
 rtl/spi_msg_timeout.sv | 33 +++
 rtl/spi_msg_seq.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/spi_msg_pkg.sv
// Shared definitions for the spi_msg command sequencer: state encodings,
// command byte layout and message geometry.
package spi_msg_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_STATUS     = 3'd1;
    localparam logic [2:0] ST_RD_FETCH   = 3'd2;
    localparam logic [2:0] ST_RD_SEND    = 3'd3;
    localparam logic [2:0] ST_WR_COLLECT = 3'd4;
    localparam logic [2:0] ST_WR_COMMIT  = 3'd5;

    typedef enum logic [2:0] {
        IDLE       = ST_IDLE,
        STATUS     = ST_STATUS,
        RD_FETCH   = ST_RD_FETCH,
        RD_SEND    = ST_RD_SEND,
        WR_COLLECT = ST_WR_COLLECT,
        WR_COMMIT  = ST_WR_COMMIT
    } state_t;

    localparam int unsigned CMD_ACCESS      = 7;
    localparam int unsigned CMD_WRITE       = 6;
    localparam logic [7:0]  DEF_STATUS_BYTE = 8'h5A;
    localparam int unsigned MSG_DATA_BYTES  = 4;

endpackage

// File: rtl/spi_msg_timeout.sv
// Register-access watchdog: loaded on start, expired once ACK_TIMEOUT cycles
// have elapsed since the start edge, stopped by clear.
module spi_msg_timeout #(
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic clk200MHz,
    input  logic reset,
    input  logic start,
    input  logic clear,
    output logic expired
);
    localparam int unsigned CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    logic [CW-1:0] count;
    logic          running;

    always_ff @(posedge clk200MHz) begin
        if (reset) begin
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            count   <= CW'(ACK_TIMEOUT - 1);
            running <= 1'b1;
        end else if (clear) begin
            running <= 1'b0;
        end else if (running && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = running && (count == '0);

endmodule

// File: rtl/spi_msg_seq.sv
// Command sequencer between the byte-level SPI slave and the register file:
// decodes the command byte, runs register handshakes, supplies MISO bytes.
module spi_msg_seq
    import spi_msg_pkg::*;
#(
    parameter logic [7:0]  STATUS_BYTE = DEF_STATUS_BYTE,
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter logic [7:0]  IDLE_TX     = 8'h00
) (
    input  logic        clk200MHz,
    input  logic        reset,
    input  logic        ss_active,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic [7:0]  tx_byte,
    output logic [3:0]  reg_addr,
    output logic        reg_re,
    output logic        reg_we,
    output logic [31:0] reg_wdata,
    input  logic [31:0] reg_rdata,
    input  logic        reg_ack,
    output logic        busy,
    output logic        err
);
    localparam logic [1:0] LAST = 2'(MSG_DATA_BYTES - 1);

    state_t      state;
    logic [1:0]  cnt;
    logic [31:0] shreg;
    logic        pend_valid;
    logic [7:0]  pend_byte;
    logic [7:0]  cmd;
    logic        cmd_ok;
    logic        tmr_start;
    logic        tmr_clear;
    logic        tmr_expired;

    // A byte parked during a write commit is decoded ahead of fresh input.
    always_comb begin
        cmd       = pend_valid ? pend_byte : rx_byte;
        cmd_ok    = ss_active && (pend_valid || rx_valid);
        tmr_start = 1'b0;
        if (state == IDLE && cmd_ok && cmd[CMD_ACCESS] && !cmd[CMD_WRITE])
            tmr_start = 1'b1;
        if (state == WR_COLLECT && ss_active && rx_valid && cnt == LAST)
            tmr_start = 1'b1;
        tmr_clear = (state != RD_FETCH) && (state != WR_COMMIT);
    end

    spi_msg_timeout #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_timeout (
        .clk200MHz(clk200MHz),
        .reset    (reset),
        .start    (tmr_start),
        .clear    (tmr_clear),
        .expired  (tmr_expired)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk200MHz) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            pend_valid <= 1'b0;
            pend_byte  <= '0;
            tx_byte    <= IDLE_TX;
            reg_addr   <= '0;
            reg_re     <= 1'b0;
            reg_we     <= 1'b0;
            reg_wdata  <= '0;
            err        <= 1'b0;
        end else begin
            err <= 1'b0;
            if (!ss_active)
                pend_valid <= 1'b0;
            // A closed frame abandons everything except an already-issued write.
            if (!ss_active && state != IDLE && state != WR_COMMIT) begin
                state   <= IDLE;
                reg_re  <= 1'b0;
                tx_byte <= IDLE_TX;
            end else begin
                unique case (state)
                    IDLE: if (cmd_ok) begin
                        pend_valid <= 1'b0;
                        reg_addr   <= cmd[3:0];
                        cnt        <= '0;
                        if (!cmd[CMD_ACCESS]) begin
                            state   <= STATUS;
                            tx_byte <= STATUS_BYTE;
                        end else if (!cmd[CMD_WRITE]) begin
                            state  <= RD_FETCH;
                            reg_re <= 1'b1;
                        end else begin
                            state <= WR_COLLECT;
                        end
                    end
                    STATUS: if (rx_valid) begin
                        state   <= IDLE;
                        tx_byte <= IDLE_TX;
                    end
                    RD_FETCH: begin
                        if (rx_valid) begin
                            err <= 1'b1;
                            cnt <= cnt + 2'd1;
                        end
                        if (reg_ack) begin
                            shreg   <= reg_rdata;
                            tx_byte <= reg_rdata[31:24];
                            reg_re  <= 1'b0;
                            state   <= RD_SEND;
                        end else if (tmr_expired) begin
                            shreg   <= '1;
                            tx_byte <= 8'hFF;
                            reg_re  <= 1'b0;
                            err     <= 1'b1;
                            state   <= RD_SEND;
                        end
                    end
                    RD_SEND: if (rx_valid) begin
                        if (cnt == LAST) begin
                            tx_byte <= IDLE_TX;
                            state   <= IDLE;
                        end else begin
                            tx_byte <= shreg[23:16];
                            shreg   <= {shreg[23:0], 8'h00};
                            cnt     <= cnt + 2'd1;
                        end
                    end
                    WR_COLLECT: if (rx_valid) begin
                        reg_wdata <= {reg_wdata[23:0], rx_byte};
                        if (cnt == LAST) begin
                            reg_we <= 1'b1;
                            state  <= WR_COMMIT;
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                    WR_COMMIT: begin
                        if (rx_valid && ss_active) begin
                            if (pend_valid)
                                err <= 1'b1;
                            pend_valid <= 1'b1;
                            pend_byte  <= rx_byte;
                        end
                        if (reg_ack) begin
                            reg_we <= 1'b0;
                            state  <= IDLE;
                        end else if (tmr_expired) begin
                            reg_we <= 1'b0;
                            err    <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
